// File: rtl/riscv_core.sv
// riscv_core: single-cycle RV32I integer core with a private 64 KiB unified
// byte-addressed memory (instance "memory"). Every rising clk edge retires one
// instruction. Optional build macro CORE_TRACE_EN compiles in a per-instruction
// $display trace; without it the design is functionally identical.

module riscv_core_mem (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  wmask,
    input  logic [15:0] iaddr,
    input  logic [15:0] daddr,
    input  logic [31:0] wdata,
    output logic [31:0] idata,
    output logic [31:0] rdata
);
    reg [7:0] m [0:65535];

    // Little-endian word reads; 16-bit address arithmetic wraps at 64 KiB.
    assign idata = {m[iaddr + 16'd3], m[iaddr + 16'd2], m[iaddr + 16'd1], m[iaddr]};
    assign rdata = {m[daddr + 16'd3], m[daddr + 16'd2], m[daddr + 16'd1], m[daddr]};

    // Byte-enabled store; misaligned accesses simply spill into following bytes.
    always @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) m[daddr + 16'(i)] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

module riscv_core (
    input  logic clk,
    input  logic rst
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc;
    reg   [31:0] rs [0:31];

    logic [31:0] instr;
    logic [31:0] load_word;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rv1, rv2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] pc_plus4;
    logic [31:0] alu_b, alu_out;
    logic [4:0]  shamt;
    logic        take;
    logic [31:0] next_pc;
    logic        rd_we;
    logic [31:0] rd_val;
    logic        mem_we;
    logic [3:0]  wmask;
    logic [15:0] ls_addr;

    riscv_core_mem memory (
        .clk   (clk),
        .we    (mem_we & ~rst),
        .wmask (wmask),
        .iaddr (pc[15:0]),
        .daddr (ls_addr),
        .wdata (rv2),
        .idata (instr),
        .rdata (load_word)
    );

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rv1      = (rs1 == 5'd0) ? 32'd0 : rs[rs1];
    assign rv2      = (rs2 == 5'd0) ? 32'd0 : rs[rs2];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'd0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

    // Shared ALU for register-register and register-immediate operations.
    always_comb begin
        alu_b   = (opcode == OP_REG) ? rv2 : imm_i;
        shamt   = alu_b[4:0];
        alu_out = '0;
        case (funct3)
            3'b000:  alu_out = (opcode == OP_REG && instr[30]) ? rv1 - alu_b : rv1 + alu_b;
            3'b001:  alu_out = rv1 << shamt;
            3'b010:  alu_out = {31'd0, $signed(rv1) < $signed(alu_b)};
            3'b011:  alu_out = {31'd0, rv1 < alu_b};
            3'b100:  alu_out = rv1 ^ alu_b;
            3'b101:  alu_out = instr[30] ? 32'($signed(rv1) >>> shamt) : rv1 >> shamt;
            3'b110:  alu_out = rv1 | alu_b;
            default: alu_out = rv1 & alu_b;
        endcase
    end

    // Branch condition; reserved funct3 codes never branch.
    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = (rv1 == rv2);
            3'b001:  take = (rv1 != rv2);
            3'b100:  take = ($signed(rv1) < $signed(rv2));
            3'b101:  take = ($signed(rv1) >= $signed(rv2));
            3'b110:  take = (rv1 < rv2);
            3'b111:  take = (rv1 >= rv2);
            default: take = 1'b0;
        endcase
    end

    // Instruction decode: next pc, register writeback and store controls.
    always_comb begin
        next_pc = pc_plus4;
        rd_we   = 1'b0;
        rd_val  = '0;
        mem_we  = 1'b0;
        wmask   = 4'b0000;
        ls_addr = rv1[15:0] + imm_i[15:0];
        case (opcode)
            OP_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OP_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = (rv1 + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (take) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000: begin rd_we = 1'b1; rd_val = {{24{load_word[7]}}, load_word[7:0]}; end
                    3'b001: begin rd_we = 1'b1; rd_val = {{16{load_word[15]}}, load_word[15:0]}; end
                    3'b010: begin rd_we = 1'b1; rd_val = load_word; end
                    3'b100: begin rd_we = 1'b1; rd_val = {24'd0, load_word[7:0]}; end
                    3'b101: begin rd_we = 1'b1; rd_val = {16'd0, load_word[15:0]}; end
                    default: rd_we = 1'b0;
                endcase
            end
            OP_STORE: begin
                ls_addr = rv1[15:0] + imm_s[15:0];
                case (funct3)
                    3'b000: begin mem_we = 1'b1; wmask = 4'b0001; end
                    3'b001: begin mem_we = 1'b1; wmask = 4'b0011; end
                    3'b010: begin mem_we = 1'b1; wmask = 4'b1111; end
                    default: mem_we = 1'b0;
                endcase
            end
            OP_IMM, OP_REG: begin
                rd_we  = 1'b1;
                rd_val = alu_out;
            end
            default: rd_we = 1'b0;
        endcase
    end

    // Architectural state: pc and register file; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) rs[i] <= '0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
        end
    end

`ifdef CORE_TRACE_EN
    // Retirement trace: pc, instruction, register write and store details.
    always @(posedge clk) begin
        if (!rst) begin
            if (rd_we && rd != 5'd0)
                $display("trace pc=%08h instr=%08h x%0d=%08h", pc, instr, rd, rd_val);
            else
                $display("trace pc=%08h instr=%08h", pc, instr);
            if (mem_we)
                $display("trace store addr=%04h data=%08h mask=%b", ls_addr, rv2, wmask);
        end
    end
`endif
endmodule

// File: tb/tb_riscv_core.sv
// Directed testbench for riscv_core: loads small programs into the core memory
// by hierarchical reference, runs a fixed number of cycles, then checks
// registers, pc and memory against hand-computed values.

module tb_riscv_core;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] prog [0:15];

    riscv_core dut (
        .clk (clk),
        .rst (rst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_i(int imm, int r1, int f3, int rd, int op);
        return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] addi(int rd, int r1, int imm);
        return enc_i(imm, r1, 0, rd, 'h13);
    endfunction

    function automatic logic [31:0] enc_r(int f7, int r2, int r1, int f3, int rd);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int r2, int r1, int f3);
        return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int r2, int r1, int f3);
        return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    // Hold reset, clear memory, load prog[0..n-1] at address 0, then release.
    task automatic load_and_start(input int n);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 65536; i++) dut.memory.m[i] = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) dut.memory.m[4*i + b] = prog[i][8*b +: 8];
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        total++; if (dut.pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", dut.pc, 32'd0); end
        for (int i = 1; i < 32; i++) begin
            total++; if (dut.rs[i] !== 32'd0) begin bad++; $display("FAIL reset_x%0d got=%h exp=%h", i, dut.rs[i], 32'd0); end
        end
    endtask

    task automatic test_arith;
        prog[0] = addi(1, 0, 5);
        prog[1] = addi(2, 0, -3);
        prog[2] = enc_r(0, 2, 1, 0, 3);        // ADD  x3,x1,x2
        prog[3] = enc_r('h20, 1, 2, 0, 4);     // SUB  x4,x2,x1
        prog[4] = enc_r(0, 1, 2, 2, 5);        // SLT  x5,x2,x1
        prog[5] = enc_r(0, 1, 2, 3, 6);        // SLTU x6,x2,x1
        load_and_start(6);
        run(6);
        total++; if (dut.rs[3] !== 32'd2) begin bad++; $display("FAIL arith_add got=%h exp=%h", dut.rs[3], 32'd2); end
        total++; if (dut.rs[4] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL arith_sub got=%h exp=%h", dut.rs[4], 32'hFFFF_FFF8); end
        total++; if (dut.rs[5] !== 32'd1) begin bad++; $display("FAIL arith_slt got=%h exp=%h", dut.rs[5], 32'd1); end
        total++; if (dut.rs[6] !== 32'd0) begin bad++; $display("FAIL arith_sltu got=%h exp=%h", dut.rs[6], 32'd0); end
        total++; if (dut.pc !== 32'h18) begin bad++; $display("FAIL arith_pc got=%h exp=%h", dut.pc, 32'h18); end
    endtask

    task automatic test_load_store;
        prog[0]  = enc_u('h12345, 1, 'h37);    // LUI  x1,0x12345
        prog[1]  = addi(1, 1, 'h678);
        prog[2]  = enc_s('h100, 1, 0, 2);      // SW   x1,0x100(x0)
        prog[3]  = enc_i('h100, 0, 0, 2, 3);   // LB   x2,0x100(x0)
        prog[4]  = enc_i('h102, 0, 5, 3, 3);   // LHU  x3,0x102(x0)
        prog[5]  = enc_s('h105, 1, 0, 0);      // SB   x1,0x105(x0)
        prog[6]  = enc_i('h101, 0, 2, 4, 3);   // LW   x4,0x101(x0) misaligned
        prog[7]  = addi(5, 0, -128);
        prog[8]  = enc_s('h110, 5, 0, 0);      // SB   x5,0x110(x0)
        prog[9]  = enc_i('h110, 0, 0, 6, 3);   // LB   x6,0x110(x0)
        prog[10] = enc_i('h110, 0, 4, 7, 3);   // LBU  x7,0x110(x0)
        prog[11] = enc_s('h120, 5, 0, 1);      // SH   x5,0x120(x0)
        prog[12] = enc_i('h120, 0, 1, 8, 3);   // LH   x8,0x120(x0)
        load_and_start(13);
        run(13);
        total++; if (dut.memory.m[16'h100] !== 8'h78) begin bad++; $display("FAIL sw_b0 got=%h exp=%h", dut.memory.m[16'h100], 8'h78); end
        total++; if (dut.memory.m[16'h101] !== 8'h56) begin bad++; $display("FAIL sw_b1 got=%h exp=%h", dut.memory.m[16'h101], 8'h56); end
        total++; if (dut.memory.m[16'h102] !== 8'h34) begin bad++; $display("FAIL sw_b2 got=%h exp=%h", dut.memory.m[16'h102], 8'h34); end
        total++; if (dut.memory.m[16'h103] !== 8'h12) begin bad++; $display("FAIL sw_b3 got=%h exp=%h", dut.memory.m[16'h103], 8'h12); end
        total++; if (dut.memory.m[16'h104] !== 8'h00) begin bad++; $display("FAIL sb_neighbor got=%h exp=%h", dut.memory.m[16'h104], 8'h00); end
        total++; if (dut.memory.m[16'h105] !== 8'h78) begin bad++; $display("FAIL sb_byte got=%h exp=%h", dut.memory.m[16'h105], 8'h78); end
        total++; if (dut.rs[2] !== 32'h78) begin bad++; $display("FAIL lb got=%h exp=%h", dut.rs[2], 32'h78); end
        total++; if (dut.rs[3] !== 32'h1234) begin bad++; $display("FAIL lhu got=%h exp=%h", dut.rs[3], 32'h1234); end
        total++; if (dut.rs[4] !== 32'h0012_3456) begin bad++; $display("FAIL lw_misaligned got=%h exp=%h", dut.rs[4], 32'h0012_3456); end
        total++; if (dut.rs[6] !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_sext got=%h exp=%h", dut.rs[6], 32'hFFFF_FF80); end
        total++; if (dut.rs[7] !== 32'h80) begin bad++; $display("FAIL lbu_zext got=%h exp=%h", dut.rs[7], 32'h80); end
        total++; if (dut.rs[8] !== 32'hFFFF_FF80) begin bad++; $display("FAIL lh_sext got=%h exp=%h", dut.rs[8], 32'hFFFF_FF80); end
    endtask

    task automatic test_branch_jump;
        for (int i = 0; i < 16; i++) prog[i] = 32'd0;
        prog[0]  = addi(1, 0, 1);
        prog[1]  = enc_b(8, 0, 1, 0);          // BEQ  x1,x0,+8 (not taken)
        prog[2]  = enc_j(8, 2);                // JAL  x2,+8
        prog[3]  = addi(3, 0, 99);
        prog[4]  = enc_b(8, 0, 1, 1);          // BNE  x1,x0,+8 (taken)
        prog[5]  = addi(3, 0, 99);
        prog[6]  = enc_b(8, 1, 0, 6);          // BLTU x0,x1,+8 (taken)
        prog[7]  = addi(3, 0, 77);
        prog[8]  = enc_i('h31, 0, 0, 4, 'h67); // JALR x4,0x31(x0) -> 0x30
        prog[12] = addi(5, 0, 1);
        load_and_start(13);
        run(3);
        total++; if (dut.pc !== 32'h10) begin bad++; $display("FAIL jal_pc got=%h exp=%h", dut.pc, 32'h10); end
        total++; if (dut.rs[2] !== 32'hC) begin bad++; $display("FAIL jal_link got=%h exp=%h", dut.rs[2], 32'hC); end
        run(4);
        total++; if (dut.pc !== 32'h34) begin bad++; $display("FAIL branch_pc got=%h exp=%h", dut.pc, 32'h34); end
        total++; if (dut.rs[3] !== 32'd0) begin bad++; $display("FAIL branch_skip got=%h exp=%h", dut.rs[3], 32'd0); end
        total++; if (dut.rs[4] !== 32'h24) begin bad++; $display("FAIL jalr_link got=%h exp=%h", dut.rs[4], 32'h24); end
        total++; if (dut.rs[5] !== 32'd1) begin bad++; $display("FAIL jalr_target got=%h exp=%h", dut.rs[5], 32'd1); end
    endtask

    task automatic test_x0_illegal;
        prog[0] = addi(0, 0, 7);
        prog[1] = 32'h0000_0000;
        prog[2] = 32'hFFFF_FFFF;
        prog[3] = addi(1, 0, 5);
        prog[4] = enc_r(0, 1, 0, 0, 2);        // ADD x2,x0,x1
        load_and_start(5);
        run(2);
        total++; if (dut.pc !== 32'h8) begin bad++; $display("FAIL illegal_pc got=%h exp=%h", dut.pc, 32'h8); end
        total++; if (dut.rs[0] !== 32'd0) begin bad++; $display("FAIL x0_write got=%h exp=%h", dut.rs[0], 32'd0); end
        run(3);
        total++; if (dut.pc !== 32'h14) begin bad++; $display("FAIL illegal2_pc got=%h exp=%h", dut.pc, 32'h14); end
        total++; if (dut.rs[31] !== 32'd0) begin bad++; $display("FAIL illegal_rd got=%h exp=%h", dut.rs[31], 32'd0); end
        total++; if (dut.rs[2] !== 32'd5) begin bad++; $display("FAIL x0_read got=%h exp=%h", dut.rs[2], 32'd5); end
    endtask

    task automatic test_shift;
        prog[0] = addi(1, 0, -16);
        prog[1] = enc_i('h402, 1, 5, 2, 'h13); // SRAI x2,x1,2
        prog[2] = enc_i(28, 1, 5, 3, 'h13);    // SRLI x3,x1,28
        prog[3] = enc_i(4, 1, 1, 4, 'h13);     // SLLI x4,x1,4
        load_and_start(4);
        run(4);
        total++; if (dut.rs[2] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL srai got=%h exp=%h", dut.rs[2], 32'hFFFF_FFFC); end
        total++; if (dut.rs[3] !== 32'hF) begin bad++; $display("FAIL srli got=%h exp=%h", dut.rs[3], 32'hF); end
        total++; if (dut.rs[4] !== 32'hFFFF_FF00) begin bad++; $display("FAIL slli got=%h exp=%h", dut.rs[4], 32'hFFFF_FF00); end
    endtask

    task automatic test_store_fetch;
        logic [31:0] w;
        w = addi(5, 0, 42);
        prog[0] = enc_u(int'(w[31:12]), 1, 'h37);
        prog[1] = addi(1, 1, int'(w[11:0]));
        prog[2] = enc_s('hC, 1, 0, 2);         // SW x1,0xC(x0): overwrite next instr
        prog[3] = addi(5, 0, 1);
        load_and_start(4);
        run(4);
        total++; if (dut.rs[5] !== 32'd42) begin bad++; $display("FAIL store_fetch got=%h exp=%h", dut.rs[5], 32'd42); end
        total++; if (dut.pc !== 32'h10) begin bad++; $display("FAIL store_fetch_pc got=%h exp=%h", dut.pc, 32'h10); end
    endtask

    task automatic test_reset_midrun;
        int nz;
        prog[0] = addi(1, 0, 1);
        prog[1] = addi(2, 0, 2);
        prog[2] = enc_s('h200, 2, 0, 2);       // SW x2,0x200(x0)
        prog[3] = addi(3, 0, 3);
        prog[4] = addi(4, 0, 4);
        prog[5] = addi(5, 0, 5);
        load_and_start(6);
        run(5);
        total++; if (dut.rs[4] !== 32'd4) begin bad++; $display("FAIL pre_reset_x4 got=%h exp=%h", dut.rs[4], 32'd4); end
        rst = 1'b1;
        #1;
        total++; if (dut.pc !== 32'd0) begin bad++; $display("FAIL midrst_pc got=%h exp=%h", dut.pc, 32'd0); end
        nz = 0;
        for (int i = 1; i < 32; i++) if (dut.rs[i] !== 32'd0) nz++;
        total++; if (nz !== 0) begin bad++; $display("FAIL midrst_regs nonzero=%0d exp=0", nz); end
        @(negedge clk);
        total++; if (dut.memory.m[16'h200] !== 8'h02) begin bad++; $display("FAIL midrst_mem got=%h exp=%h", dut.memory.m[16'h200], 8'h02); end
        total++; if (dut.memory.m[16'h0] !== prog[0][7:0]) begin bad++; $display("FAIL midrst_prog got=%h exp=%h", dut.memory.m[16'h0], prog[0][7:0]); end
        rst = 1'b0;
        run(1);
        total++; if (dut.pc !== 32'h4) begin bad++; $display("FAIL restart_pc got=%h exp=%h", dut.pc, 32'h4); end
        total++; if (dut.rs[1] !== 32'd1) begin bad++; $display("FAIL restart_x1 got=%h exp=%h", dut.rs[1], 32'd1); end
        total++; if (dut.rs[2] !== 32'd0) begin bad++; $display("FAIL restart_x2 got=%h exp=%h", dut.rs[2], 32'd0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) prog[i] = 32'd0;
        test_reset();
        test_arith();
        test_load_store();
        test_branch_jump();
        test_x0_illegal();
        test_shift();
        test_store_fetch();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_core.md
# riscv_core

Single-cycle RV32I integer core with a private, unified 64 KiB byte-addressed memory; the top-level execution block of the design. The core has no external bus. Program and data are preloaded by simulation through the memory instance, and results are inspected through the register file and memory arrays by hierarchical reference.

## Interface
- No parameters. Memory size fixed at 65536 bytes; 32 architectural registers.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- Hierarchical names are part of the contract:
  - memory instance `memory`, containing `reg [7:0] m [0:65535]`, loadable by `$readmemh` over 0x0000–0xFFFF.
  - register file `reg [31:0] rs [0:31]`, where `rs[i]` holds xi.

## Operation
- Each cycle fetches, decodes, executes and retires exactly one instruction.
- Fetch:
  - instruction = {m[pc+3], m[pc+2], m[pc+1], m[pc]}, little-endian.
  - Memory address = low 16 bits of any computed address; wraps mod 64 KiB.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit0 cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU; SB, SH, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Immediates are sign-extended per RV32I I/S/B/U/J formats. Shift amount is the low 5 bits.
- x0:
  - writes to rd=0 are discarded;
  - reads of register 0 return 0 regardless of `rs[0]` contents.
- Loads/stores:
  - little-endian byte accesses to m;
  - misaligned addresses are permitted and handled bytewise;
  - LB/LH sign-extend, LBU/LHU zero-extend.
- Next PC:
  - pc+4 by default;
  - pc+immB on a taken branch;
  - pc+immJ for JAL, with rd=pc+4;
  - (rs1+immI)&~1 for JALR, with rd=pc+4, where rs1 is read before the rd write.
- Any other opcode (FENCE, SYSTEM, illegal): no architectural effect except pc+4.
- No interrupts, exceptions or CSRs.

## Timing
- Instruction fetch, register read, ALU and load data are combinational within the cycle.
- On each rising clk edge with rst low:
  - rd written (if applicable);
  - store bytes written to m;
  - pc updated.
- Latency: one instruction per cycle. A load result is usable by the next instruction.
- Reset (rst high, asynchronous, at any time including mid-program):
  - pc=0 immediately;
  - all rs[1..31]=0;
  - no memory write occurs while rst is high;
  - m contents preserved.
- First instruction executes on the first rising edge after rst deasserts; that instruction is at address 0.
- A store and an instruction fetch in the same cycle are independent. A store into the next instruction's bytes takes effect for that fetch (write occurs at the edge before the fetch).

## Configuration
- CORE_TRACE_EN defined:
  - on every retiring edge, `$display` prints pc, instruction word, and rd/value when a register is written;
  - on every store, also prints address and data.
- CORE_TRACE_EN undefined: no display statements compiled; functionally identical.

## Test plan
- Reset mid-run:
  - stimulus: assert rst for one cycle after 5 instructions have retired.
  - required: pc=0, x1..x31=0, memory unchanged; execution restarts at 0x0.
- Arithmetic:
  - program: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SLT x5,x2,x1; SLTU x6,x2,x1.
  - required: x3=2, x4=0xFFFFFFF8, x5=1, x6=0.
- Load/store:
  - program: LUI x1,0x12345; ADDI x1,x1,0x678; SW x1,0x100(x0); LB x2,0x100(x0); LHU x3,0x102(x0); SB x1,0x105(x0).
  - required: m[0x100..0x103]=78 56 34 12, x2=0x78, x3=0x1234, m[0x105]=0x78.
- Branch/jump:
  - program: ADDI x1,x0,1; BEQ x1,x0,+8; JAL x2,+8 at 0x8.
  - required: branch not taken; x2=0xC; pc reaches 0x10.
- x0 and illegal opcode:
  - program: ADDI x0,x0,7 followed by word 0x00000000.
  - required: reg 0 reads 0; illegal word only advances pc by 4.
- Sign-extending shifts:
  - program: ADDI x1,x0,-16; SRAI x2,x1,2; SRLI x3,x1,28.
  - required: x2=0xFFFFFFFC, x3=0xF.
